// File: rtl/paddle_emu_pkg.sv
// paddle_emu_pkg: shared constants and helpers for the paddle emulator.
//   - ps2_mouse field bit positions
//   - GRAY_FWD / GRAY_BWD : driving-controller Gray sequence 00->01->11->10
//   - sat8                : 10-bit signed to 8-bit signed saturation
//   - step_clamp          : shift and clamp a raw 9-bit mouse delta
package paddle_emu_pkg;

  localparam int MS_STB     = 24;
  localparam int MS_Y_LSB   = 16;
  localparam int MS_X_LSB   = 8;
  localparam int MS_Y_SGN   = 5;
  localparam int MS_X_SGN   = 4;
  localparam int MS_BTN_LSB = 0;

  function automatic logic [1:0] GRAY_FWD(input logic [1:0] g);
    case (g)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] GRAY_BWD(input logic [1:0] g);
    case (g)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    if (v > 10'sd127)       return 8'sh7f;
    else if (v < -10'sd128) return 8'sh80;
    else                    return v[7:0];
  endfunction

  // raw is {sign, byte}; arithmetic shift keeps the sign, clamp bounds the step.
  function automatic logic signed [7:0] step_clamp(input logic signed [8:0] raw,
                                                   input int shift, input int max_step);
    int s;
    s = raw;
    s = s >>> shift;
    if (s > max_step)       s = max_step;
    else if (s < -max_step) s = -max_step;
    return 8'(s);
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// paddle_axis: one saturating paddle accumulator channel.
//   clk_sys, reset_n : clock, async active-low reset
//   pkt_en           : apply this cycle's step
//   clr              : zero the accumulator (wins over pkt_en)
//   raw              : signed 9-bit mouse delta {sign, byte}
//   step             : clamped (and optionally negated) step, combinational
//   acc              : signed 8-bit position
module paddle_axis
  import paddle_emu_pkg::*;
#(
  parameter int DIV_SHIFT = 1,
  parameter int MAX_STEP  = 10,
  parameter bit NEG       = 1'b0
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pkt_en,
  input  logic       clr,
  input  logic [8:0] raw,
  output logic [7:0] step,
  output logic [7:0] acc
);

  logic signed [7:0] stp;
  logic signed [9:0] nxt;

  always_comb begin
    stp = step_clamp(signed'(raw), DIV_SHIFT, MAX_STEP);
    if (NEG) stp = -stp;
    // 10-bit sum cannot overflow for 8-bit operands, so sat8 sees the true value
    nxt = 10'(signed'(acc)) + 10'(stp);
  end

  assign step = stp;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)    acc <= '0;
    else if (clr)    acc <= '0;
    else if (pkt_en) acc <= sat8(nxt);
  end

endmodule

// File: rtl/paddle_emu.sv
// paddle_emu: PS/2 mouse to paddle / driving-controller emulator.
//   clk_sys, reset_n : clock, async active-low reset
//   ps2_mouse        : [24] strobe toggle, [23:16] Y, [15:8] X, [5] Y sign, [4] X sign, [1:0] buttons
//   joya             : signed analog axes, axis n at [8n+7:8n]
//   recenter         : pulse, zero accumulators and drive counter
//   paddle           : signed paddle positions (mouse acc or analog passthrough)
//   mouse_active     : paddles come from the mouse
//   btn              : mouse buttons while mouse_active
//   drive_gray       : driving-controller Gray code from axis-0 motion
module paddle_emu
  import paddle_emu_pkg::*;
#(
  parameter int NUM_AXES  = 2,
  parameter int DIV_SHIFT = 1,
  parameter int MAX_STEP  = 10,
  parameter bit INV_Y     = 1'b0,
  parameter int DRV_DIV   = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [24:0]           ps2_mouse,
  input  logic [8*NUM_AXES-1:0] joya,
  input  logic                  recenter,
  output logic [8*NUM_AXES-1:0] paddle,
  output logic                  mouse_active,
  output logic [1:0]            btn,
  output logic [1:0]            drive_gray
);

  localparam logic signed [8:0] DRV_S = 9'(DRV_DIV);

  logic [NUM_AXES-1:0][7:0] acc, step, joy_v;
  logic stb_s, stb_old, pkt, takeover, clr;
  logic signed [8:0] drv_cnt, drv_post, drv_nxt;
  logic signed [9:0] drv_sum;
  logic [1:0]        gray_nxt;

  assign joy_v    = joya;
  assign pkt      = stb_s != stb_old;
  assign takeover = |joya;
  // clear dominates a packet inside the axes, which gives takeover > recenter > packet
  assign clr      = takeover | recenter;

  for (genvar n = 0; n < NUM_AXES; n++) begin : g_axis
    logic [8:0] raw;
    if (n == 0)      begin : g_x assign raw = {ps2_mouse[MS_X_SGN], ps2_mouse[MS_X_LSB +: 8]}; end
    else if (n == 1) begin : g_y assign raw = {ps2_mouse[MS_Y_SGN], ps2_mouse[MS_Y_LSB +: 8]}; end
    else             begin : g_a assign raw = '0; end

    paddle_axis #(
      .DIV_SHIFT (DIV_SHIFT),
      .MAX_STEP  (MAX_STEP),
      .NEG       ((n == 1) ? INV_Y : 1'b0)
    ) u_axis (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .pkt_en  ((n < 2) ? pkt : 1'b0),
      .clr     (clr),
      .raw     (raw),
      .step    (step[n]),
      .acc     (acc[n])
    );
  end

  always_comb begin
    for (int n = 0; n < NUM_AXES; n++)
      paddle[8*n +: 8] = mouse_active ? acc[n] : joy_v[n];
  end

  assign btn = mouse_active ? ps2_mouse[MS_BTN_LSB +: 2] : 2'b00;

  // Drive counter: add the axis-0 step, saturate to +/-255, then take at most
  // one Gray step per clock so a large residual drains over following edges.
  always_comb begin
    drv_sum = 10'(drv_cnt) + (pkt ? 10'(signed'(step[0])) : 10'sd0);
    if (drv_sum > 10'sd255)       drv_post = 9'sd255;
    else if (drv_sum < -10'sd255) drv_post = -9'sd255;
    else                          drv_post = drv_sum[8:0];
    drv_nxt  = drv_post;
    gray_nxt = drive_gray;
    if (drv_post >= DRV_S) begin
      drv_nxt  = drv_post - DRV_S;
      gray_nxt = GRAY_FWD(drive_gray);
    end else if (drv_post <= -DRV_S) begin
      drv_nxt  = drv_post + DRV_S;
      gray_nxt = GRAY_BWD(drive_gray);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stb_s        <= 1'b0;
      stb_old      <= 1'b0;
      mouse_active <= 1'b0;
      drv_cnt      <= '0;
      drive_gray   <= 2'b00;
    end else begin
      stb_s   <= ps2_mouse[MS_STB];
      stb_old <= stb_s;
      if (takeover) begin
        mouse_active <= 1'b0;
        drv_cnt      <= '0;
      end else if (recenter) begin
        drv_cnt <= '0;
      end else begin
        if (pkt) mouse_active <= 1'b1;
        drv_cnt    <= drv_nxt;
        drive_gray <= gray_nxt;
      end
    end
  end

  // Fields not used by this block.
  logic unused_bits;
  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2], step[NUM_AXES-1:1]};

endmodule

// File: tb/tb_paddle_emu.sv
// tb_paddle_emu: directed vectors with hand-computed expectations for paddle_emu
// (NUM_AXES=2, DIV_SHIFT=1, MAX_STEP=10, INV_Y=0, DRV_DIV=8).
module tb_paddle_emu;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [24:0] ps2;
  logic [15:0] joya;
  logic        recenter;
  logic [15:0] paddle;
  logic        mouse_active;
  logic [1:0]  btn, drive_gray;

  int nchk = 0;
  int nerr = 0;

  always #5 clk_sys = ~clk_sys;

  paddle_emu #(
    .NUM_AXES(2), .DIV_SHIFT(1), .MAX_STEP(10), .INV_Y(1'b0), .DRV_DIV(8)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_mouse    (ps2),
    .joya         (joya),
    .recenter     (recenter),
    .paddle       (paddle),
    .mouse_active (mouse_active),
    .btn          (btn),
    .drive_gray   (drive_gray)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sample/drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_pkt(input logic xs, input logic [7:0] xb,
                         input logic ys, input logic [7:0] yb, input logic [1:0] b);
    ps2[23:16] = yb;
    ps2[15:8]  = xb;
    ps2[5]     = ys;
    ps2[4]     = xs;
    ps2[1:0]   = b;
    ps2[24]    = ~ps2[24];
  endtask

  task automatic pkt(input logic xs, input logic [7:0] xb,
                     input logic ys, input logic [7:0] yb);
    set_pkt(xs, xb, ys, yb, 2'b00);
    tick();
    tick();
  endtask

  task automatic do_recenter();
    recenter = 1'b1;
    tick();
    recenter = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ps2     = '0;
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [1:0] gseq [5];
    int e;
    gseq[0] = 2'b00; gseq[1] = 2'b01; gseq[2] = 2'b11; gseq[3] = 2'b10; gseq[4] = 2'b00;

    reset_n = 1'b0; ps2 = '0; joya = '0; recenter = 1'b0;
    tick(); tick();
    chk("rst_paddle", 32'(paddle), 32'h0);
    chk("rst_active", 32'(mouse_active), 32'h0);
    chk("rst_gray", 32'(drive_gray), 32'h0);
    chk("rst_btn", 32'(btn), 32'h0);
    reset_n = 1'b1;
    tick();

    // first packet: +4 >>> 1 = +2, visible exactly 2 edges after the toggle
    set_pkt(1'b0, 8'h04, 1'b0, 8'h00, 2'b10);
    tick();
    chk("lat1_active", 32'(mouse_active), 32'h0);
    chk("lat1_btn", 32'(btn), 32'h0);
    tick();
    chk("lat2_active", 32'(mouse_active), 32'h1);
    chk("lat2_x", 32'(paddle[7:0]), 32'h02);
    chk("lat2_btn", 32'(btn), 32'h2);

    // Y axis: -8 >>> 1 = -4
    pkt(1'b0, 8'h00, 1'b1, 8'hf8);
    chk("y_neg", 32'(paddle[15:8]), 32'hfc);
    chk("y_x_hold", 32'(paddle[7:0]), 32'h02);

    do_recenter();
    chk("recenter_x", 32'(paddle[7:0]), 32'h00);
    chk("recenter_active", 32'(mouse_active), 32'h1);

    // positive saturation: step 10 per packet, clip at 127
    for (int i = 1; i <= 14; i++) begin
      pkt(1'b0, 8'h64, 1'b0, 8'h00);
      e = (10 * i > 127) ? 127 : 10 * i;
      chk($sformatf("sat_pos_%0d", i), 32'(paddle[7:0]), 32'(e));
    end

    // negative saturation: -100 -> -50 -> -10, clip at -128
    do_recenter();
    for (int i = 1; i <= 14; i++) pkt(1'b1, 8'h9c, 1'b0, 8'h00);
    chk("sat_neg", 32'(paddle[7:0]), 32'h80);

    // analog takeover on the same edge as a packet
    do_recenter();
    for (int i = 0; i < 4; i++) pkt(1'b0, 8'h64, 1'b0, 8'h00);
    chk("pre_take", 32'(paddle[7:0]), 32'h28);
    joya = 16'he030;
    set_pkt(1'b0, 8'h64, 1'b0, 8'h00, 2'b11);
    tick(); tick();
    chk("take_active", 32'(mouse_active), 32'h0);
    chk("take_paddle", 32'(paddle), 32'he030);
    chk("take_btn", 32'(btn), 32'h0);
    joya = '0;
    tick();
    chk("take_idle", 32'(paddle), 32'h0);
    pkt(1'b0, 8'h64, 1'b0, 8'h00);
    chk("post_take_x", 32'(paddle[7:0]), 32'h0a);
    chk("post_take_active", 32'(mouse_active), 32'h1);

    // asynchronous reset mid-run
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_active", 32'(mouse_active), 32'h0);
    ps2 = '0;
    #1;
    reset_n = 1'b1;
    tick();
    pkt(1'b0, 8'h04, 1'b0, 8'h00);
    chk("async_acc_clr", 32'(paddle[7:0]), 32'h02);

    // driving controller: step +4, one Gray step per 2 packets
    do_recenter();
    chk("drv_start", 32'(drive_gray), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      pkt(1'b0, 8'h08, 1'b0, 8'h00);
      chk($sformatf("drv_fwd_%0d", i), 32'(drive_gray), 32'(gseq[i/2]));
    end
    pkt(1'b0, 8'h64, 1'b0, 8'h00);              // 0+10 -> 2, one step
    chk("drv_big", 32'(drive_gray), 32'h1);
    pkt(1'b0, 8'h04, 1'b0, 8'h00);              // 4
    pkt(1'b0, 8'h04, 1'b0, 8'h00);              // 6
    chk("drv_resid_6", 32'(drive_gray), 32'h1);
    pkt(1'b0, 8'h04, 1'b0, 8'h00);              // 8 -> 0, step
    chk("drv_resid_8", 32'(drive_gray), 32'h3);
    do_recenter();
    chk("drv_recenter_hold", 32'(drive_gray), 32'h3);

    // backward direction from a fresh reset
    do_reset();
    pkt(1'b1, 8'h9c, 1'b0, 8'h00);              // -10 -> -2, 00->10
    chk("drv_bwd_1", 32'(drive_gray), 32'h2);
    pkt(1'b1, 8'h9c, 1'b0, 8'h00);              // -12 -> -4, 10->11
    chk("drv_bwd_2", 32'(drive_gray), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/paddle_emu.md
Name: paddle_emu

Overview:
Parametrised paddle/driving-controller emulator. It converts PS/2 mouse motion packets into saturating 8-bit signed paddle positions for NUM_AXES channels, with automatic hand-over between mouse and analog joystick sources. It also generates a 2-bit Gray-code driving-controller output from axis-0 motion. It sits between hps_io (ps2_mouse, joystick_analog) and the console core's paddle inputs in the emu top, and replaces the inline mouse-to-paddle logic there.

Parameters:
NUM_AXES, 2, number of paddle channels (2..4); axis 0 = mouse X, axis 1 = mouse Y, axes >=2 analog only
DIV_SHIFT, 1, arithmetic right shift applied to raw mouse delta (0..3)
MAX_STEP, 10, per-packet step clamp magnitude (1..127)
INV_Y, 0, 1 = negate axis-1 step
DRV_DIV, 8, accumulated axis-0 counts per Gray step (1..64)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_mouse  in  25  [24] strobe toggle, [23:16] Y delta, [15:8] X delta, [5] Y sign, [4] X sign, [1:0] buttons
joya  in  8*NUM_AXES  analog axis values, signed, axis n at [8n+7:8n]
recenter  in  1  single-cycle pulse; zero accumulators
paddle  out  8*NUM_AXES  signed paddle positions
mouse_active  out  1  1 = paddles driven from mouse
btn  out  2  mouse buttons when mouse_active, else 0
drive_gray  out  2  driving-controller Gray code

Behaviour:
- Reset (async, reset_n=0): acc[n]=0, drv_cnt=0, drive_gray=2'b00, mouse_active=0, stb_s/stb_old=0. paddle = joya (combinational mux), btn=0.
- Strobe detect: stb_s <= ps2_mouse[24]; a packet event occurs on the edge where stb_s != stb_old; stb_old <= stb_s. Packet fields are sampled on that edge.
- Latency: a toggle presented before edge k appears in paddle/mouse_active after edge k+1 (2 edges).
- Step per mouse axis: raw = signed 9-bit {sign, byte}; s = raw >>> DIV_SHIFT; step = clamp(s, -MAX_STEP, +MAX_STEP). Axis 1 step is negated if INV_Y.
- Accumulate on a packet: nxt = acc + step, computed in 10 bits; acc <= sat(nxt) to [-128, 127]. No wrap-around ever. Axes >= 2 never change from the mouse.
- Packet event also sets mouse_active=1.
- Analog takeover: if any joya byte is nonzero on an edge, then mouse_active<=0, all acc<=0, drv_cnt<=0. This has priority over a simultaneous packet, and that packet is dropped. drive_gray holds.
- recenter: acc<=0, drv_cnt<=0 on that edge, drive_gray holds. Priority order: takeover > recenter > packet.
- Output mux: paddle[n] = mouse_active ? acc[n] : joya[n]. btn = mouse_active ? ps2_mouse[1:0] : 0.
- Driving counter: drv_cnt is signed, 9 bits.
  - On a packet, drv_cnt += axis-0 step.
  - Each edge, evaluate the post-packet value:
    - if >= DRV_DIV: subtract DRV_DIV and advance Gray forward (00->01->11->10->00).
    - else if <= -DRV_DIV: add DRV_DIV and step backward.
  - At most one Gray step per clock; the residual drains on following edges.
  - drv_cnt saturates at +/-255.

Decomposition:
- paddle_emu_pkg holds:
  - mouse field bit-position constants
  - GRAY_FWD/GRAY_BWD next-state functions
  - sat8 function (10-bit to 8-bit saturation)
  - step_clamp function
- Sub-module paddle_axis: one accumulator channel (step clamp, saturating add, clear). Instantiated NUM_AXES times via generate; instances for axes >= 2 have the packet enable tied off.
- Top level holds strobe sync, takeover/recenter priority, output mux, and the drive counter plus Gray FSM.

Test Plan:
- reset_n=0 with joya=0, then release -> paddle=0, mouse_active=0, drive_gray=00, btn=0; an async assert mid-run clears acc immediately.
- joya=0; toggle with X sign=0, byte=0x04 (DIV_SHIFT=1) -> step +2; paddle[7:0]=0x02 and mouse_active=1 exactly 2 edges after the toggle.
- X byte=0x64 (+100 -> 50 -> clamp 10), 13 packets -> paddle[7:0] goes 10,20..120, then 127 (0x7F) and stays at 127 on a 14th packet.
- X sign=1, byte=0x9C (-100 -> -10), 13 packets from 0 -> paddle[7:0]=0x80 (-128), no wrap.
- Mouse active with acc0=0x28; set joya[7:0]=0x30 on the same edge as a packet -> mouse_active=0, acc cleared, paddle[7:0]=0x30, packet ignored; a later packet with joya=0 gives acc=step only.
- DRV_DIV=8; 8 packets of X=+8 (step +4) -> drive_gray sequence 00,01,11,10,00, one change per 2 packets; one packet of X=+0x64 (step +10) -> one forward step, drv_cnt=2; X=-0x64 from drv_cnt=0 -> drive_gray 00->10.
